// File: rtl/audio_pkg.sv
// Shared audio definitions for the output stage: sample widths, frame geometry,
// the stereo sample-pair record and I2S word-select encodings.
package audio_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int FRAME_SLOTS = 32;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] left;
        logic signed [SAMPLE_W-1:0] right;
    } sample_pair_t;

    // Word select runs one slot ahead of the data it qualifies.
    function automatic logic slot_ws(input logic [SLOT_W-1:0] slot);
        return (slot >= SLOT_W'(15) && slot <= SLOT_W'(30)) ? I2S_RIGHT : I2S_LEFT;
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair valid/ready handshake between the filter datapath and the I2S transmitter.
interface i2s_tx_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] left_in;
    logic [SAMPLE_W-1:0] right_in;
    logic                sample_valid;
    logic                sample_ready;

    modport master (output left_in, output right_in, output sample_valid, input sample_ready);
    modport slave  (input left_in, input right_in, input sample_valid, output sample_ready);

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every CLK_DIV system clocks and strobes
// fall_evt_o on the clk edge where bclk goes from 1 to 0.
module i2s_bclk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    output logic bclk_o,
    output logic fall_evt_o
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("i2s_bclk_gen: CLK_DIV must be at least 2");
    end

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             wrap;

    assign wrap = (div_cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        bclk_d    = bclk_q;
        if (wrap) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    // Combinational so the top updates its outputs on the very edge bclk falls.
    assign fall_evt_o = wrap & bclk_q;
    assign bclk_o     = bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-deep sample-pair holding register feeding a
// 32-slot frame shifter; silence and an underflow pulse when a frame starts empty.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int WIDTH   = SAMPLE_W
) (
    input  logic     clk,
    input  logic     rst,
    i2s_tx_if.slave  s_if,
    output logic     bclk,
    output logic     lrclk,
    output logic     sdata,
    output logic     underflow
);

    if (WIDTH != SAMPLE_W) begin : g_bad_width
        $error("i2s_tx: WIDTH must equal SAMPLE_W");
    end

    logic fall_evt;

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
        .clk        (clk),
        .rst        (rst),
        .bclk_o     (bclk),
        .fall_evt_o (fall_evt)
    );

    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               full_q, full_d;
    logic               ready_q, ready_d;
    sample_pair_t       hold_q, hold_d;
    logic [2*WIDTH-1:0] shift_q, shift_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               uf_q, uf_d;
    logic               handshake;
    logic               frame_start;

    assign handshake   = s_if.sample_valid & ready_q;
    assign frame_start = fall_evt & (slot_q == SLOT_W'(FRAME_SLOTS - 1));

    always_comb begin
        slot_d  = slot_q;
        full_d  = full_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        uf_d    = 1'b0;

        if (fall_evt) begin
            slot_d  = slot_q + 1'b1;
            shift_d = {shift_q[2*WIDTH-2:0], 1'b0};
            // The load decision looks at the pre-edge full flag, so a pair
            // arriving on this same edge waits for the next frame.
            if (frame_start) begin
                if (full_q) begin
                    shift_d = hold_q;
                    full_d  = 1'b0;
                end else begin
                    shift_d = '0;
                    uf_d    = 1'b1;
                end
            end
            sdata_d = shift_d[2*WIDTH-1];
            lrclk_d = slot_ws(slot_d);
        end

        if (handshake) begin
            full_d       = 1'b1;
            hold_d.left  = s_if.left_in;
            hold_d.right = s_if.right_in;
        end

        ready_d = ~full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= SLOT_W'(FRAME_SLOTS - 1);
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            hold_q  <= '0;
            shift_q <= '0;
            lrclk_q <= I2S_LEFT;
            sdata_q <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            full_q  <= full_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            uf_q    <= uf_d;
        end
    end

    assign s_if.sample_ready = ready_q;
    assign lrclk             = lrclk_q;
    assign sdata             = sdata_q;
    assign underflow         = uf_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a frame scoreboard on a CLK_DIV=2 instance plus
// a hand-written extreme-value frame on a CLK_DIV=8 instance.
module tb_i2s_tx;
    import audio_pkg::*;

    localparam int DIV_A        = 2;
    localparam int DIV_B        = 8;
    localparam int FRAME_CLKS_A = 64 * DIV_A;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    i2s_tx_if if_a ();
    i2s_tx_if if_b ();

    logic bclk_a, lrclk_a, sdata_a, uf_a;
    logic bclk_b, lrclk_b, sdata_b, uf_b;

    i2s_tx #(.CLK_DIV(DIV_A), .WIDTH(16)) dut_a (
        .clk(clk), .rst(rst_a), .s_if(if_a),
        .bclk(bclk_a), .lrclk(lrclk_a), .sdata(sdata_a), .underflow(uf_a)
    );

    i2s_tx #(.CLK_DIV(DIV_B), .WIDTH(16)) dut_b (
        .clk(clk), .rst(rst_b), .s_if(if_b),
        .bclk(bclk_b), .lrclk(lrclk_b), .sdata(sdata_b), .underflow(uf_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- scoreboard for instance A ----------------
    typedef struct {
        logic [31:0] frame;
        int          acc_edge;
    } exp_t;

    exp_t sb_q[$];
    int   edge_a;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) edge_a <= 0;
        else       edge_a <= edge_a + 1;
    end

    logic        bclk_prev, last_sd, last_lr, frame_live, exp_uf;
    int          mslot, uf_cnt, frame_no;
    int          uf_edges[$];
    logic [31:0] cur_exp, got_word;

    initial begin
        uf_cnt   = 0;
        frame_no = 0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                bclk_prev  = 1'b0;
                last_sd    = 1'b0;
                last_lr    = 1'b0;
                mslot      = 31;
                frame_live = 1'b0;
                cur_exp    = '0;
                got_word   = '0;
                sb_q.delete();
            end else begin
                if (bclk_prev && !bclk_a) begin
                    mslot = (mslot + 1) % 32;
                    if (mslot == 0) begin
                        // A pair counts for this frame only if accepted before this edge.
                        exp_uf = !(sb_q.size() > 0 && sb_q[0].acc_edge < edge_a);
                        check("underflow_at_frame_start", 32'(uf_a), 32'(exp_uf));
                        if (exp_uf) begin
                            cur_exp = '0;
                        end else begin
                            exp_t e;
                            e = sb_q.pop_front();
                            cur_exp = e.frame;
                        end
                        frame_live = 1'b1;
                        got_word   = '0;
                    end
                    check("lrclk_slot", 32'(lrclk_a), 32'((mslot >= 15 && mslot <= 30) ? 1 : 0));
                    got_word[31-mslot] = sdata_a;
                    if (frame_live && mslot == 31) begin
                        frame_no++;
                        $display("frame %0d: sdata %h required %h", frame_no, got_word, cur_exp);
                        check("frame_data", got_word, cur_exp);
                        frame_live = 1'b0;
                    end
                end else begin
                    check("underflow_quiet", 32'(uf_a), 32'(0));
                    check("sdata_stable", 32'(sdata_a), 32'(last_sd));
                    check("lrclk_stable", 32'(lrclk_a), 32'(last_lr));
                end
                if (uf_a) begin
                    uf_cnt++;
                    uf_edges.push_back(edge_a);
                end
                last_sd   = sdata_a;
                last_lr   = lrclk_a;
                bclk_prev = bclk_a;
            end
        end
    end

    // ---------------- drivers for instance A ----------------
    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] frame;
    } vec_t;

    vec_t vecs[5];

    // Called just after a negedge; returns on the negedge after the handshake.
    task automatic send(input logic [15:0] l, input logic [15:0] r, input logic [31:0] f);
        int   w;
        exp_t e;
        w = 0;
        if_a.left_in      = l;
        if_a.right_in     = r;
        if_a.sample_valid = 1'b1;
        while (!if_a.sample_ready && w < 3 * FRAME_CLKS_A) begin
            @(negedge clk);
            w++;
        end
        if (!if_a.sample_ready) begin
            timeout_fail("send_ready");
        end else begin
            e.frame    = f;
            e.acc_edge = edge_a + 1;
            sb_q.push_back(e);
            $display("send: left %h right %h accepted at edge %0d", l, r, e.acc_edge);
        end
        @(negedge clk);
        if_a.sample_valid = 1'b0;
    endtask

    // Called just after a negedge; asserts rst between clock edges.
    task automatic reset_a();
        #2 rst_a = 1'b1;
        if_a.sample_valid = 1'b0;
        #1;
        check("reset_outputs{bclk,lrclk,sdata,uf,ready}",
              32'({bclk_a, lrclk_a, sdata_a, uf_a, if_a.sample_ready}), 32'(5'b00001));
        repeat (2) @(negedge clk);
        #1 rst_a = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while ((sb_q.size() != 0 || frame_live) && w < 4 * FRAME_CLKS_A) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (sb_q.size() != 0 || frame_live) timeout_fail(name);
    endtask

    // First pair right after reset: offered at edge 1, taken at edge 2.
    task automatic first_pair();
        @(negedge clk);
        #1;
        check("bclk_low_edge1", 32'(bclk_a), 32'(0));
        send(vecs[0].l, vecs[0].r, vecs[0].frame);
        #1;
        check("ready_drop_edge2", 32'(if_a.sample_ready), 32'(0));
        check("bclk_first_rise_edge2", 32'(bclk_a), 32'(1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w, uf_base, k, nbits, cyc_rise0, cyc_rise1, uf_seen_b;
        logic b_prev;
        logic [31:0] word_b;

        vecs[0] = '{16'hA5C3, 16'h0F01, 32'hA5C3_0F01};
        vecs[1] = '{16'h8000, 16'h7FFF, 32'h8000_7FFF};
        vecs[2] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
        vecs[3] = '{16'h1234, 16'h5678, 32'h1234_5678};
        vecs[4] = '{16'h0001, 16'h8001, 32'h0001_8001};

        if_a.left_in = '0; if_a.right_in = '0; if_a.sample_valid = 1'b0;
        if_b.left_in = '0; if_b.right_in = '0; if_b.sample_valid = 1'b0;

        // Underflow: idle after reset.
        @(negedge clk);
        reset_a();
        uf_edges.delete();
        w = 0;
        while (edge_a < 2 * DIV_A + FRAME_CLKS_A + 8 && w < 1000) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("underflow_count_idle", 32'(uf_edges.size()), 32'(2));
        if (uf_edges.size() == 2) begin
            check("underflow_first_edge", 32'(uf_edges[0]), 32'(2 * DIV_A));
            check("underflow_second_edge", 32'(uf_edges[1]), 32'(2 * DIV_A + FRAME_CLKS_A));
        end

        // Collision: handshake lands exactly on the third frame-start edge.
        w = 0;
        while (edge_a != 2 * DIV_A + 2 * FRAME_CLKS_A - 1 && w < 1000) begin
            @(negedge clk);
            #1;
            w++;
        end
        uf_base = uf_cnt;
        send(16'hC0DE, 16'h1357, 32'hC0DE_1357);
        #1;
        check("collision_underflow", 32'(uf_cnt - uf_base), 32'(1));
        wait_drain("collision_drain");

        // Basic frame and back-pressured table.
        reset_a();
        uf_base = uf_cnt;
        first_pair();
        for (int i = 1; i < 5; i++) send(vecs[i].l, vecs[i].r, vecs[i].frame);
        wait_drain("table_drain");
        check("no_underflow_backpressure", 32'(uf_cnt - uf_base), 32'(0));

        // Mid-frame reset at slot 20, then restart like the basic frame.
        @(negedge clk);
        send(16'h5A5A, 16'hFFFF, 32'h5A5A_FFFF);
        w = 0;
        while (!(frame_live && mslot == 20 && cur_exp == 32'h5A5A_FFFF) && w < 4 * FRAME_CLKS_A) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 4 * FRAME_CLKS_A) timeout_fail("slot20_wait");
        check("pre_reset_lrclk_slot20", 32'(lrclk_a), 32'(1));
        @(negedge clk);
        reset_a();
        uf_base = uf_cnt;
        first_pair();
        wait_drain("restart_drain");
        check("no_underflow_restart", 32'(uf_cnt - uf_base), 32'(0));

        // Extremes on the CLK_DIV=8 instance.
        @(negedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        if_b.left_in = 16'h8000; if_b.right_in = 16'h7FFF; if_b.sample_valid = 1'b1;
        check("b_ready_before", 32'(if_b.sample_ready), 32'(1));
        @(negedge clk);
        if_b.sample_valid = 1'b0;
        check("b_ready_after", 32'(if_b.sample_ready), 32'(0));
        k = 2; nbits = 0; cyc_rise0 = -1; cyc_rise1 = -1; uf_seen_b = 0;
        b_prev = bclk_b; word_b = '0;
        while (nbits < 32 && k < 700) begin
            @(negedge clk);
            k++;
            if (uf_b) uf_seen_b++;
            if (!b_prev && bclk_b) begin
                if (cyc_rise0 < 0) cyc_rise0 = k;
                else if (cyc_rise1 < 0) cyc_rise1 = k;
            end
            if (b_prev && !bclk_b) begin
                word_b[31-nbits] = sdata_b;
                nbits++;
            end
            b_prev = bclk_b;
        end
        if (nbits < 32) timeout_fail("b_frame_wait");
        $display("frame div8: sdata %h required %h", word_b, 32'h8000_7FFF);
        check("b_first_rise_edge", 32'(cyc_rise0), 32'(DIV_B));
        check("b_bclk_period", 32'(cyc_rise1 - cyc_rise0), 32'(2 * DIV_B));
        check("b_frame_data", word_b, 32'h8000_7FFF);
        check("b_no_underflow", 32'(uf_seen_b), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
